// File: rtl/wb_dbg_pkg.sv
// Shared constants and state encoding for the serial-to-Wishbone debug master.
package wb_dbg_pkg;

  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    SEL   = 3'd2,
    DATA  = 3'd3,
    BUS   = 3'd4,
    RESP  = 3'd5,
    RDATA = 3'd6
  } state_e;

  function automatic logic [63:0] shift_in_byte(input logic [63:0] r, input logic [7:0] b);
    return {r[55:0], b};
  endfunction

endpackage

// File: rtl/wb_dbg_txser.sv
// 64-bit load, MSB-first byte serialiser with a valid/ready handshake.
module wb_dbg_txser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic [2:0]  load_last,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last
);

  logic [63:0] shift_r;
  logic [2:0]  cnt_r;
  logic        valid_r;

  assign tx_data  = shift_r[63:56];
  assign tx_valid = valid_r;
  assign tx_last  = valid_r & tx_ready & (cnt_r == 3'd0);

  // Shift register: a load wins over an accept in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= 64'h0;
      cnt_r   <= 3'd0;
      valid_r <= 1'b0;
    end else if (load) begin
      shift_r <= load_data;
      cnt_r   <= load_last;
      valid_r <= 1'b1;
    end else if (valid_r && tx_ready) begin
      if (cnt_r == 3'd0) begin
        valid_r <= 1'b0;
      end else begin
        shift_r <= {shift_r[55:0], 8'h00};
        cnt_r   <= cnt_r - 3'd1;
      end
    end
  end

endmodule

// File: rtl/wb_dbg_master.sv
// Byte-stream command parser driving single 64-bit Wishbone cycles, with a
// byte-serial status/read-data response.
module wb_dbg_master
  import wb_dbg_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1024,
  parameter int RX_TIMEOUT  = 65536
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [63:0] wbm_adr_o,
  output logic [63:0] wbm_dat_o,
  input  logic [63:0] wbm_dat_i,
  output logic [7:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy_o
);

  localparam int AW = $clog2(ACK_TIMEOUT);
  localparam int RW = $clog2(RX_TIMEOUT);

  state_e        state_r;
  logic          we_r;
  logic          ok_r;
  logic          busy_r;
  logic          cyc_r;
  logic          bus_we_r;
  logic [2:0]    cnt_r;
  logic [63:0]   adr_r;
  logic [63:0]   dat_r;
  logic [7:0]    sel_r;
  logic [63:0]   rdata_r;
  logic [RW-1:0] rx_tmo_r;
  logic [AW-1:0] ack_tmo_r;

  logic          rx_tmo_hit_s;
  logic          ack_tmo_hit_s;
  logic          bus_done_s;
  logic          bus_ok_s;
  logic          load_s;
  logic [63:0]   load_data_s;
  logic [2:0]    load_last_s;
  logic          tx_last_s;

  assign rx_tmo_hit_s  = (rx_tmo_r == RW'(RX_TIMEOUT - 1));
  assign ack_tmo_hit_s = (ack_tmo_r == AW'(ACK_TIMEOUT - 1));
  assign bus_done_s    = cyc_r & (wbm_ack_i | wbm_err_i | ack_tmo_hit_s);
  assign bus_ok_s      = wbm_ack_i & ~wbm_err_i;

  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = dat_r;
  assign wbm_sel_o = sel_r;
  assign wbm_we_o  = bus_we_r;
  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = cyc_r;
  assign busy_o    = busy_r;

  // Serialiser loads: status byte when the bus cycle ends, read data after 'K' goes out.
  always_comb begin
    load_s      = 1'b0;
    load_data_s = 64'h0;
    load_last_s = 3'd0;
    if (state_r == BUS && bus_done_s) begin
      load_s      = 1'b1;
      load_data_s = {(bus_ok_s ? RSP_OK : RSP_ERR), 56'h0};
    end else if (state_r == RESP && tx_last_s && ok_r && !we_r) begin
      load_s      = 1'b1;
      load_data_s = rdata_r;
      load_last_s = 3'd7;
    end else begin
      load_s = 1'b0;
    end
  end

  // Frame parser, bus control and response sequencing.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r   <= IDLE;
      we_r      <= 1'b0;
      ok_r      <= 1'b0;
      busy_r    <= 1'b0;
      cyc_r     <= 1'b0;
      bus_we_r  <= 1'b0;
      cnt_r     <= 3'd0;
      adr_r     <= 64'h0;
      dat_r     <= 64'h0;
      sel_r     <= 8'h00;
      rdata_r   <= 64'h0;
      rx_tmo_r  <= {RW{1'b0}};
      ack_tmo_r <= {AW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (rx_valid_i && (rx_data_i == CMD_RD || rx_data_i == CMD_WR)) begin
            we_r     <= (rx_data_i == CMD_WR);
            cnt_r    <= 3'd0;
            rx_tmo_r <= {RW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= ADDR;
          end
        end
        ADDR: begin
          if (rx_valid_i) begin
            adr_r    <= shift_in_byte(adr_r, rx_data_i);
            cnt_r    <= cnt_r + 3'd1;
            rx_tmo_r <= {RW{1'b0}};
            if (cnt_r == 3'd7) state_r <= SEL;
          end else if (rx_tmo_hit_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            rx_tmo_r <= rx_tmo_r + 1'b1;
          end
        end
        SEL: begin
          if (rx_valid_i) begin
            sel_r    <= rx_data_i;
            rx_tmo_r <= {RW{1'b0}};
            if (we_r) begin
              state_r <= DATA;
            end else begin
              cyc_r     <= 1'b1;
              bus_we_r  <= 1'b0;
              ack_tmo_r <= {AW{1'b0}};
              state_r   <= BUS;
            end
          end else if (rx_tmo_hit_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            rx_tmo_r <= rx_tmo_r + 1'b1;
          end
        end
        DATA: begin
          if (rx_valid_i) begin
            dat_r    <= shift_in_byte(dat_r, rx_data_i);
            cnt_r    <= cnt_r + 3'd1;
            rx_tmo_r <= {RW{1'b0}};
            if (cnt_r == 3'd7) begin
              cyc_r     <= 1'b1;
              bus_we_r  <= 1'b1;
              ack_tmo_r <= {AW{1'b0}};
              state_r   <= BUS;
            end
          end else if (rx_tmo_hit_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            rx_tmo_r <= rx_tmo_r + 1'b1;
          end
        end
        BUS: begin
          // err overrides a simultaneous ack; a timeout reports as an error.
          if (bus_done_s) begin
            cyc_r    <= 1'b0;
            bus_we_r <= 1'b0;
            ok_r     <= bus_ok_s;
            if (bus_ok_s) rdata_r <= wbm_dat_i;
            state_r  <= RESP;
          end else begin
            ack_tmo_r <= ack_tmo_r + 1'b1;
          end
        end
        RESP: begin
          if (tx_last_s) begin
            if (ok_r && !we_r) begin
              state_r <= RDATA;
            end else begin
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        RDATA: begin
          if (tx_last_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          cyc_r    <= 1'b0;
          bus_we_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  wb_dbg_txser u_txser (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .load      (load_s),
    .load_data (load_data_s),
    .load_last (load_last_s),
    .tx_ready  (tx_ready_i),
    .tx_data   (tx_data_o),
    .tx_valid  (tx_valid_o),
    .tx_last   (tx_last_s)
  );

endmodule
